// File: rtl/doorlock_ctrl_param_pkg.sv
// rtl/doorlock_ctrl_param_pkg.sv - shared key codes, digit width and state encoding for the doorlock controller
package doorlock_ctrl_param_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] KEY_STAR = 4'd10;
    localparam logic [DIGIT_W-1:0] KEY_HASH = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_FAIL,
        S_OPEN,
        S_NEW1,
        S_NEW2,
        S_STORE,
        S_LOCKOUT
    } state_e;

endpackage

// File: rtl/doorlock_code_buf.sv
// rtl/doorlock_code_buf.sv - shift-in BCD digit buffer with count, overflow flag and clear
module doorlock_code_buf
    import doorlock_ctrl_param_pkg::*;
#(
    parameter int CODE_LEN = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clr_i,
    input  logic                                push_i,
    input  logic [DIGIT_W-1:0]                  digit_i,
    output logic [CODE_LEN*DIGIT_W-1:0]         data_o,
    output logic [$clog2(CODE_LEN+1)-1:0]       cnt_o,
    output logic                                ovf_o
);

    localparam int CW = $clog2(CODE_LEN + 1);
    localparam int BW = CODE_LEN * DIGIT_W;

    logic [BW-1:0] data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    // A digit beyond CODE_LEN only flags overflow; the held digits stay put.
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        if (clr_i) begin
            data_d = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
        end else if (push_i) begin
            if (cnt_q == CW'(CODE_LEN)) begin
                ovf_d = 1'b1;
            end else begin
                data_d = {data_q[BW-DIGIT_W-1:0], digit_i};
                cnt_d  = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    assign data_o = data_q;
    assign cnt_o  = cnt_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/doorlock_ctrl_param.sv
// rtl/doorlock_ctrl_param.sv - parametrised keypad doorlock with lockout, timeout, timed unlock and code change
module doorlock_ctrl_param
    import doorlock_ctrl_param_pkg::*;
#(
    parameter int                          CODE_LEN     = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
    parameter int                          MAX_FAIL     = 3,
    parameter int                          UNLOCK_CYC   = 200,
    parameter int                          LOCKOUT_CYC  = 1000,
    parameter int                          TIMEOUT_CYC  = 500,
    parameter int                          STORE_CYC    = 5
) (
    input  logic                               CLK,
    input  logic                               rst,
    input  logic                               sw_reset,
    input  logic                               key_valid,
    input  logic [DIGIT_W-1:0]                 key_code,
    output logic                               lockOP,
    output logic                               storeLED,
    output logic                               errLED,
    output logic                               lockout,
    output logic [$clog2(MAX_FAIL+1)-1:0]      fail_cnt,
    output logic [$clog2(CODE_LEN+1)-1:0]      digit_cnt
);

    localparam int CW = $clog2(CODE_LEN + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int BW = CODE_LEN * DIGIT_W;
    localparam int M1 = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
    localparam int M2 = (TIMEOUT_CYC > STORE_CYC) ? TIMEOUT_CYC : STORE_CYC;
    localparam int TW = $clog2(((M1 > M2) ? M1 : M2) + 1);
    localparam logic [TW-1:0] T_TO = TW'(TIMEOUT_CYC - 1);

    state_e        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [FW-1:0] fail_q, fail_d;
    logic [BW-1:0] code_q, code_d;
    logic          err_q, err_d;

    logic          push_a, push_b, clr_a, clr_b;
    logic [BW-1:0] data_a, data_b;
    logic [CW-1:0] cnt_a, cnt_b;
    logic          ovf_a, ovf_b;

    logic is_digit, is_star, is_hash;
    logic full_a, full_b, match_a, match_b, tmr_zero;
    logic [TW-1:0] tmr_dn;
    logic [FW-1:0] fail_inc;

    assign is_digit = key_valid && (key_code < KEY_STAR);
    assign is_star  = key_valid && (key_code == KEY_STAR);
    assign is_hash  = key_valid && (key_code == KEY_HASH);
    assign full_a   = (cnt_a == CW'(CODE_LEN)) && !ovf_a;
    assign full_b   = (cnt_b == CW'(CODE_LEN)) && !ovf_b;
    assign match_a  = full_a && (data_a == code_q);
    assign match_b  = full_b && (data_b == data_a);
    assign tmr_zero = (tmr_q == '0);
    assign tmr_dn   = tmr_q - TW'(1);
    assign fail_inc = fail_q + FW'(1);

    // Buffer A serves ENTRY and NEW1 (and must survive into NEW2); buffer B holds the confirmation copy.
    doorlock_code_buf #(.CODE_LEN(CODE_LEN)) u_buf_a (
        .clk(CLK), .rst(rst), .clr_i(clr_a), .push_i(push_a), .digit_i(key_code),
        .data_o(data_a), .cnt_o(cnt_a), .ovf_o(ovf_a)
    );

    doorlock_code_buf #(.CODE_LEN(CODE_LEN)) u_buf_b (
        .clk(CLK), .rst(rst), .clr_i(clr_b), .push_i(push_b), .digit_i(key_code),
        .data_o(data_b), .cnt_o(cnt_b), .ovf_o(ovf_b)
    );

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        fail_d  = fail_q;
        code_d  = code_q;
        err_d   = 1'b0;
        push_a  = 1'b0;
        push_b  = 1'b0;
        case (state_q)
            S_IDLE: if (is_digit) begin
                push_a  = 1'b1;
                state_d = S_ENTRY;
            end
            S_ENTRY: begin
                if (is_digit) begin
                    push_a = 1'b1;
                    tmr_d  = T_TO;
                end else if (is_star) begin
                    state_d = match_a ? S_OPEN : S_FAIL;
                    if (match_a) fail_d = '0;
                end else if (is_hash) begin
                    state_d = match_a ? S_NEW1 : S_FAIL;
                end else if (tmr_zero) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_dn;
                end
            end
            S_FAIL: begin
                fail_d  = fail_inc;
                state_d = (fail_inc == FW'(MAX_FAIL)) ? S_LOCKOUT : S_IDLE;
            end
            S_OPEN: begin
                if (is_star || tmr_zero) state_d = S_IDLE;
                else                     tmr_d   = tmr_dn;
            end
            S_NEW1: begin
                if (is_digit) begin
                    push_a = 1'b1;
                    tmr_d  = T_TO;
                end else if (is_hash) begin
                    state_d = full_a ? S_NEW2 : S_IDLE;
                    err_d   = !full_a;
                end else if (is_star || tmr_zero) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_dn;
                end
            end
            S_NEW2: begin
                if (is_digit) begin
                    push_b = 1'b1;
                    tmr_d  = T_TO;
                end else if (is_hash) begin
                    state_d = match_b ? S_STORE : S_IDLE;
                    err_d   = !match_b;
                    if (match_b) code_d = data_b;
                end else if (is_star || tmr_zero) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_dn;
                end
            end
            S_STORE: begin
                if (tmr_zero) state_d = S_IDLE;
                else          tmr_d   = tmr_dn;
            end
            S_LOCKOUT: begin
                if (tmr_zero) begin
                    state_d = S_IDLE;
                    fail_d  = '0;
                end else begin
                    tmr_d = tmr_dn;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_FAIL) err_d = 1'b1;

        // Every state entry loads the timer for that state.
        if (state_d != state_q) begin
            case (state_d)
                S_OPEN:    tmr_d = TW'(UNLOCK_CYC - 1);
                S_STORE:   tmr_d = TW'(STORE_CYC - 1);
                S_LOCKOUT: tmr_d = TW'(LOCKOUT_CYC - 1);
                default:   tmr_d = T_TO;
            endcase
        end

        clr_a = sw_reset || ((state_d != state_q) && (state_q != S_IDLE)
                             && !(state_q == S_NEW1 && state_d == S_NEW2));
        clr_b = sw_reset || (state_d != state_q);
    end

    always_ff @(posedge CLK) begin
        if (rst || sw_reset) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            fail_q  <= '0;
            code_q  <= DEFAULT_CODE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            fail_q  <= fail_d;
            code_q  <= code_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        case (state_q)
            S_ENTRY, S_NEW1: digit_cnt = cnt_a;
            S_NEW2:          digit_cnt = cnt_b;
            default:         digit_cnt = '0;
        endcase
    end

    assign lockOP   = (state_q == S_OPEN);
    assign storeLED = (state_q == S_STORE);
    assign lockout  = (state_q == S_LOCKOUT);
    assign errLED   = err_q;
    assign fail_cnt = fail_q;

endmodule

// File: tb/tb_doorlock_ctrl_param.sv
// tb/tb_doorlock_ctrl_param.sv - directed bench with an output-pulse scoreboard for doorlock_ctrl_param
module tb_doorlock_ctrl_param;

    localparam int EV_OPEN  = 1;
    localparam int EV_ERR   = 2;
    localparam int EV_STORE = 3;
    localparam int EV_LOCK  = 4;

    typedef struct {
        int kind;
        int len;
    } ev_t;

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic       sw_reset = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       lockOP, storeLED, errLED, lockout;
    logic [1:0] fail_cnt;
    logic [2:0] digit_cnt;

    int  checks = 0;
    int  failures = 0;
    ev_t exp_q[$];
    int  run[4] = '{0, 0, 0, 0};

    doorlock_ctrl_param #(
        .CODE_LEN(4), .DEFAULT_CODE(16'h1234), .MAX_FAIL(3), .UNLOCK_CYC(20),
        .LOCKOUT_CYC(50), .TIMEOUT_CYC(30), .STORE_CYC(5)
    ) dut (
        .CLK(CLK), .rst(rst), .sw_reset(sw_reset), .key_valid(key_valid), .key_code(key_code),
        .lockOP(lockOP), .storeLED(storeLED), .errLED(errLED), .lockout(lockout),
        .fail_cnt(fail_cnt), .digit_cnt(digit_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input int kind, input int len);
        ev_t e;
        e.kind = kind;
        e.len  = len;
        exp_q.push_back(e);
    endtask

    task automatic ev_done(input int kind, input int len);
        ev_t e;
        check("event_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            check("event_len", len, e.len);
        end
    endtask

    // Measure every output pulse at the falling edge and hand its kind/length to the scoreboard.
    always @(negedge CLK) begin
        logic [3:0] s;
        s = {lockout, storeLED, errLED, lockOP};
        for (int i = 0; i < 4; i++) begin
            if (s[i]) begin
                run[i]++;
            end else if (run[i] > 0) begin
                ev_done(i + 1, run[i]);
                run[i] = 0;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        @(posedge CLK);
        #1;
        key_valid = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic press_seq(input logic [63:0] seq, input int n);
        logic [3:0] k;
        for (int i = 0; i < n; i++) begin
            k = seq[4*(n-1-i) +: 4];
            press(k);
        end
    endtask

    initial begin
        cycles(3);
        check("rst_lockOP", int'(lockOP), 0);
        check("rst_storeLED", int'(storeLED), 0);
        check("rst_errLED", int'(errLED), 0);
        check("rst_lockout", int'(lockout), 0);
        check("rst_fail_cnt", int'(fail_cnt), 0);
        check("rst_digit_cnt", int'(digit_cnt), 0);
        rst = 1'b0;
        cycles(1);

        press(4'd12);
        press(4'd10);
        check("ignored_keys_digit_cnt", int'(digit_cnt), 0);

        // Unlock with default code
        press_seq(64'h1234A, 5);
        push_ev(EV_OPEN, 20);
        check("unlock_lockOP", int'(lockOP), 1);
        check("unlock_fail_cnt", int'(fail_cnt), 0);
        cycles(22);

        // Short entry and overflow
        press_seq(64'h123, 3);
        check("short_digit_cnt", int'(digit_cnt), 3);
        press(4'd10);
        push_ev(EV_ERR, 1);
        check("short_lockOP", int'(lockOP), 0);
        press_seq(64'h12345, 5);
        check("ovf_digit_cnt", int'(digit_cnt), 4);
        press(4'd10);
        push_ev(EV_ERR, 1);
        check("ovf_fail_cnt", int'(fail_cnt), 2);
        check("ovf_lockOP", int'(lockOP), 0);

        press_seq(64'h1234A, 5);
        push_ev(EV_OPEN, 20);
        check("open_clears_fail", int'(fail_cnt), 0);
        cycles(22);

        // Lockout after three failures
        for (int i = 0; i < 3; i++) begin
            press_seq(64'h9999A, 5);
            push_ev(EV_ERR, 1);
        end
        push_ev(EV_LOCK, 50);
        check("lock_fail_cnt", int'(fail_cnt), 3);
        check("lock_active", int'(lockout), 1);
        press_seq(64'h1234A, 5);
        check("lock_ignores_keys", int'(lockOP), 0);
        check("lock_still_active", int'(lockout), 1);
        cycles(45);
        check("lock_released", int'(lockout), 0);
        check("lock_fail_cleared", int'(fail_cnt), 0);
        press_seq(64'h1234A, 5);
        push_ev(EV_OPEN, 20);
        cycles(22);

        // Confirmation mismatch keeps old code
        press_seq(64'h1234B7891B4700B, 15);
        push_ev(EV_ERR, 1);
        check("mismatch_fail_cnt", int'(fail_cnt), 0);
        check("mismatch_storeLED", int'(storeLED), 0);
        press_seq(64'h1234A, 5);
        push_ev(EV_OPEN, 20);
        cycles(22);

        // Code change to 7891
        press_seq(64'h1234B7891B, 10);
        check("new2_digit_cnt_empty", int'(digit_cnt), 0);
        press_seq(64'h7891, 4);
        check("new2_digit_cnt_full", int'(digit_cnt), 4);
        press(4'd11);
        push_ev(EV_STORE, 5);
        check("store_led", int'(storeLED), 1);
        cycles(6);
        press_seq(64'h1234A, 5);
        push_ev(EV_ERR, 1);
        check("old_code_fail_cnt", int'(fail_cnt), 1);
        press_seq(64'h7891A, 5);
        push_ev(EV_OPEN, 20);
        check("new_code_fail_cnt", int'(fail_cnt), 0);
        cycles(22);

        // Inactivity timeout
        press_seq(64'h12, 2);
        check("to_digit_cnt", int'(digit_cnt), 2);
        cycles(28);
        check("to_last_cycle", int'(digit_cnt), 2);
        cycles(1);
        check("to_expired", int'(digit_cnt), 0);
        check("to_no_err", int'(errLED), 0);
        check("to_fail_cnt", int'(fail_cnt), 0);

        // Admin restore, then reset during OPEN
        sw_reset = 1'b1;
        cycles(1);
        sw_reset = 1'b0;
        press_seq(64'h1234A, 5);
        check("sw_reset_open", int'(lockOP), 1);
        cycles(5);
        rst = 1'b1;
        cycles(1);
        check("rst_mid_open", int'(lockOP), 0);
        push_ev(EV_OPEN, 7);
        rst = 1'b0;
        cycles(3);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
